// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// flag bundle, plus the signed-overflow helpers used by ADD and SUB.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOP = 3'b100,
        OP_XOR = 3'b101,
        OP_SLT = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{zero: 1'b1, carry: 1'b0, overflow: 1'b0, negative: 1'b0};

    // Arguments are the sign bits of op1, op2 and the truncated result.
    function automatic logic add_overflow(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_overflow(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per enabled cycle,
// with done and product presented combinationally during the final step.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               en,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (en) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    // The last step's sum is handed out directly so the top can register it on the same edge.
    assign done    = en && (cnt_q == CNT_W'(WIDTH - 1));
    assign product = acc_d;

    // NOTE: the datapath registers are small, so they take the async reset too; this keeps the block fully deterministic out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with handshake input: single-cycle logic/arithmetic ops and an
// iterative unsigned multiply, producing registered result, flags and a valid pulse.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_op1,
    input  logic [WIDTH-1:0]   i_op2,
    input  logic [2:0]         selector,
    output logic [2*WIDTH-1:0] Result_op,
    output logic               o_valid,
    output logic               Zeroflag,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_negative
);

    op_e                op;
    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    flags_t             flags_q, flags_d;
    logic               valid_q, valid_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_val;
    flags_t             alu_flags;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign op   = op_e'(selector);
    assign sum  = {1'b0, i_op1} + {1'b0, i_op2};
    // The extra top bit of the difference is the unsigned borrow.
    assign diff = {1'b0, i_op1} - {1'b0, i_op2};

    always_comb begin
        alu_val            = '0;
        alu_flags          = '0;
        case (op)
            OP_ADD: begin
                alu_val            = sum[WIDTH-1:0];
                alu_flags.carry    = sum[WIDTH];
                alu_flags.overflow = add_overflow(i_op1[WIDTH-1], i_op2[WIDTH-1], sum[WIDTH-1]);
            end
            OP_SUB: begin
                alu_val            = diff[WIDTH-1:0];
                alu_flags.carry    = diff[WIDTH];
                alu_flags.overflow = sub_overflow(i_op1[WIDTH-1], i_op2[WIDTH-1], diff[WIDTH-1]);
            end
            OP_AND:  alu_val = i_op1 & i_op2;
            OP_OR:   alu_val = i_op1 | i_op2;
            OP_XOR:  alu_val = i_op1 ^ i_op2;
            OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
            default: alu_val = '0;
        endcase
        alu_flags.zero     = (alu_val == '0);
        alu_flags.negative = alu_val[WIDTH-1];
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (i_clk),
        .rst     (i_rst),
        .start   (mul_start),
        .en      (state_q == S_BUSY),
        .op_a    (i_op1),
        .op_b    (i_op2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        valid_d   = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = S_BUSY;
                    end else begin
                        valid_d = 1'b1;
                        if (op != OP_NOP) begin
                            result_d = {{WIDTH{1'b0}}, alu_val};
                            flags_d  = alu_flags;
                        end
                    end
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    result_d = mul_product;
                    flags_d  = '{zero: (mul_product == '0), carry: 1'b0, overflow: 1'b0,
                                 negative: mul_product[2*WIDTH-1]};
                    valid_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= FLAGS_RESET;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
        end
    end

    assign o_ready    = (state_q == S_IDLE);
    assign o_valid    = valid_q;
    assign Result_op  = result_q;
    assign Zeroflag   = flags_q.zero;
    assign o_carry    = flags_q.carry;
    assign o_overflow = flags_q.overflow;
    assign o_negative = flags_q.negative;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16: directed operations push hand-computed
// expectations; a negedge monitor pops one per o_valid pulse and compares.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           i_rst;
    logic           i_valid;
    logic           o_ready;
    logic [W-1:0]   i_op1;
    logic [W-1:0]   i_op2;
    logic [2:0]     selector;
    logic [2*W-1:0] Result_op;
    logic           o_valid;
    logic           Zeroflag;
    logic           o_carry;
    logic           o_overflow;
    logic           o_negative;

    typedef struct {
        int             id;
        logic [2*W-1:0] res;
        logic [3:0]     fl;   // {zero, carry, overflow, negative}
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    alu_seq #(.WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op1      (i_op1),
        .i_op2      (i_op2),
        .selector   (selector),
        .Result_op  (Result_op),
        .o_valid    (o_valid),
        .Zeroflag   (Zeroflag),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_negative (o_negative)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: each o_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!i_rst && o_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got o_valid=1 (Result_op=0x%0h), expected no pulse", Result_op);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("result#%0d", e.id), Result_op, e.res);
                check($sformatf("flags#%0d", e.id), {28'd0, Zeroflag, o_carry, o_overflow, o_negative},
                      {28'd0, e.fl});
            end
        end
    end

    task automatic issue(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] res, input logic [3:0] fl, input bit push,
                         output int waited);
        exp_t e;
        @(negedge clk);
        i_valid  = 1'b1;
        selector = sel;
        i_op1    = a;
        i_op2    = b;
        if (push) begin
            e.id  = next_id;
            e.res = res;
            e.fl  = fl;
            sb_q.push_back(e);
            next_id++;
        end
        waited = 0;
        while (!o_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!o_ready) check("accept_timeout", {31'd0, o_ready}, 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic op(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] res, input logic [3:0] fl);
        int w;
        issue(sel, a, b, res, fl, 1'b1, w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, Result_op, 32'd0);
        check({tag, "_outs"}, {26'd0, Zeroflag, o_carry, o_overflow, o_negative, o_valid, o_ready},
              {26'd0, 6'b100001});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int lat;
        int low;
        int w;
        i_rst    = 1'b1;
        i_valid  = 1'b0;
        i_op1    = '0;
        i_op2    = '0;
        selector = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        i_rst = 1'b0;

        // Single-cycle arithmetic and flag corners.
        op(OP_ADD, 16'd10, 16'd22, 32'd32, 4'b0000);
        op(OP_SUB, 16'd20, 16'd20, 32'd0, 4'b1000);
        op(OP_SUB, 16'd5, 16'd7, 32'h0000_FFFE, 4'b0101);
        op(OP_ADD, 16'hFFFF, 16'h0001, 32'd0, 4'b1100);
        op(OP_ADD, 16'h7FFF, 16'h0001, 32'h0000_8000, 4'b0011);
        op(OP_SUB, 16'h8000, 16'h0001, 32'h0000_7FFF, 4'b0010);

        // Multiply latency and ready window.
        op(OP_MUL, 16'd300, 16'd500, 32'h0002_49F0, 4'b0000);
        lat = 0;
        low = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!o_ready) low++;
        end while (!o_valid && lat < 40);
        check("mul_latency", lat, 32'd17);
        check("mul_ready_low_cycles", low, 32'd16);
        check("mul_ready_with_valid", {31'd0, o_ready}, 32'd1);

        // An ADD held during BUSY is accepted only once o_ready rises.
        op(OP_MUL, 16'h1234, 16'h0010, 32'h0001_2340, 4'b0000);
        issue(OP_ADD, 16'd3, 16'd4, 32'd7, 4'b0000, 1'b1, w);
        check("held_add_wait", w, 32'd16);

        op(OP_XOR, 16'h00F0, 16'h00FF, 32'h0000_000F, 4'b0000);
        op(OP_SLT, 16'hFFFF, 16'h0001, 32'd1, 4'b0000);
        op(OP_NOP, 16'hAAAA, 16'h5555, 32'd1, 4'b0000);
        op(OP_SUB, 16'd5, 16'd7, 32'h0000_FFFE, 4'b0101);
        op(OP_NOP, 16'h0000, 16'h0000, 32'h0000_FFFE, 4'b0101);

        // Back-to-back logic ops, then multiply corner cases.
        op(OP_AND, 16'hF0F0, 16'hFF00, 32'h0000_F000, 4'b0001);
        op(OP_OR, 16'h0F0F, 16'h00F0, 32'h0000_0FFF, 4'b0000);
        op(OP_SLT, 16'h0001, 16'hFFFF, 32'd0, 4'b1000);
        op(OP_MUL, 16'd0, 16'h1234, 32'd0, 4'b1000);
        op(OP_MUL, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 4'b0001);
        op(OP_ADD, 16'd9, 16'd1, 32'd10, 4'b0000);

        // Reset in cycle 8 of a multiply aborts it with no valid pulse.
        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 32'd0, 4'b0000, 1'b0, w);
        repeat (8) @(negedge clk);
        i_rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        repeat (20) @(negedge clk);
        check_reset_outputs("after_abort");
        op(OP_ADD, 16'd1, 16'd1, 32'd2, 4'b0000);

        repeat (5) @(negedge clk);
        check("queue_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised successor to the team's combinational 16-bit ALU. It accepts one operation per handshake and adds XOR, signed set-less-than and an iterative unsigned multiply. It also produces zero/carry/overflow/negative flags and delivers a one-cycle result-valid pulse. It sits between the instruction decode stage and register write-back in the processor datapath.

## Interface
Parameters:
- WIDTH, 16: operand width in bits (minimum 4).

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  operation request; accepted when i_valid && o_ready at a rising edge.
- o_ready  output  1  block can accept a request; low while a multiply is in progress.
- i_op1  input  WIDTH  first operand.
- i_op2  input  WIDTH  second operand.
- selector  input  3  operation code.
- Result_op  output  2*WIDTH  registered result.
- o_valid  output  1  one-cycle pulse marking Result_op and flags as new.
- Zeroflag  output  1  Result_op == 0 over all 2*WIDTH bits.
- o_carry  output  1  ADD carry-out or SUB borrow.
- o_overflow  output  1  signed overflow of ADD or SUB.
- o_negative  output  1  result MSB: bit WIDTH-1, or bit 2*WIDTH-1 for MUL.

Clocking and reset are fixed: one clock; reset is asynchronous and active-high.

## Operation
Selector encoding:
- 000 ADD
- 001 SUB (op1 - op2)
- 010 AND
- 011 OR
- 100 NOP
- 101 XOR
- 110 SLT (signed op1 < op2 gives 1, else 0)
- 111 MUL (unsigned, full 2*WIDTH product)

Result and flag rules:
- Non-MUL results are WIDTH bits, zero-extended into Result_op. Upper WIDTH bits are 0, including for SUB.
- o_carry is set only by ADD (carry-out of bit WIDTH-1) and SUB (1 when op1 < op2 unsigned). It is 0 for all other ops.
- o_overflow is set only by ADD and SUB, using two's-complement sign rules. It is 0 for all other ops.
- NOP leaves Result_op and all flags unchanged but still produces the o_valid pulse.

State machine:
- IDLE: o_ready=1. An accepted non-MUL op loads result and flags at the accepting edge and pulses o_valid for one cycle. An accepted MUL latches both operands, clears the accumulator and counter, and moves to BUSY.
- BUSY: o_ready=0. Each cycle runs one shift-add step on the lowest unprocessed multiplier bit. When the counter reaches WIDTH, the block writes Result_op and flags, pulses o_valid and returns to IDLE.
- i_valid while o_ready=0 is ignored; the requester must hold it.
- Operands and selector are sampled only at acceptance. Changes during BUSY have no effect.
- There is no output backpressure; a consumer must capture on o_valid.

## Timing
- Reset: Result_op=0, Zeroflag=1, o_carry=0, o_overflow=0, o_negative=0, o_valid=0, o_ready=1, state IDLE.
- Non-MUL latency is 1 cycle: o_valid is high in the cycle after the accepting edge. Back-to-back acceptance every cycle gives one o_valid per cycle.
- MUL latency is WIDTH+1 cycles from the accepting edge to o_valid high. o_ready is low for WIDTH cycles and rises in the same cycle as o_valid, so a new request can be accepted on the edge that ends that o_valid cycle.
- Reset asserted mid-MUL aborts the multiply immediately: reset values apply and no o_valid is produced.
- Multiplying by 0 still takes the full WIDTH+1 cycles and gives Zeroflag=1.

## Structure
- Package alu_pkg holds:
  - the 3-bit op enum (OP_ADD … OP_MUL);
  - the state enum (S_IDLE, S_BUSY);
  - a flag-bundle struct.
- Sub-module alu_mul_iter: WIDTH-parameterised shift-add multiplier with start/done, holding the counter, multiplicand shift register and accumulator.
- The top level holds the combinational ALU for single-cycle ops, the FSM and the output registers.

## Test plan
All scenarios use WIDTH=16.
- ADD 10 + 22 → Result_op=32 one cycle after accept, o_valid single pulse, Zeroflag=0, o_carry=0.
- SUB 20 - 20 → Result_op=0, Zeroflag=1. Then SUB 5 - 7 → Result_op=0x0000FFFE, o_carry=1, o_negative=1.
- ADD 0xFFFF + 0x0001 → Result_op=0, o_carry=1, Zeroflag=1. Then ADD 0x7FFF + 0x0001 → 0x8000, o_overflow=1, o_negative=1.
- MUL 300 × 500 → o_ready low for 16 cycles, o_valid on cycle 17, Result_op=150000 (0x000249F0). An i_valid ADD issued during BUSY is not accepted until o_ready rises.
- XOR 0x00F0 ^ 0x00FF → 0x000F. Then SLT 0xFFFF vs 0x0001 → 1. Then NOP → Result_op stays 1, o_valid pulses.
- Assert i_rst at cycle 8 of a MUL 0xFFFF × 0xFFFF → all outputs at reset values, no o_valid. After release, an ADD 1 + 1 returns 2.
